// File: rtl/synth_voice_pkg.sv
// Shared constants and FSM state encoding for the 8-voice note allocator.
package synth_voice_pkg;
    localparam int NOTE_W      = 7;
    localparam int VOICE_IDX_W = 3;
    localparam int NUM_VOICES  = 8;
    localparam int SCAN_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        ASSIGN  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } alloc_state_e;
endpackage

// File: rtl/voice_allocator_dmux8way.sv
// 1-to-8 demultiplexer: fans the voice write strobe out to a one-hot per-voice strobe.
module DMux8Way
    import synth_voice_pkg::*;
(
    input  logic                   in_i,
    input  logic [VOICE_IDX_W-1:0] sel_i,
    output logic [NUM_VOICES-1:0]  out_o
);
    // Decode the select into a single active lane when the input strobe is high
    always_comb begin
        out_o = {NUM_VOICES{1'b0}};
        if (in_i) begin
            out_o[sel_i] = 1'b1;
        end else begin
            out_o = {NUM_VOICES{1'b0}};
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Round-robin note-event scheduler for the 8-voice synth engine.
// Optional feature: define VOICE_STEAL_EN to reassign voice rr_ptr when all voices are busy.
module voice_allocator #(
    parameter int NOTE_W = 7,
    parameter int VOICES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic [NOTE_W-1:0] ev_note,
    input  logic              panic,
    output logic              voice_wr,
    output logic [2:0]        voice_sel,
    output logic [NOTE_W-1:0] voice_note,
    output logic [7:0]        voice_wr_vec,
    output logic [7:0]        voice_gate,
    output logic              voice_steal,
    output logic              ev_drop
);
    import synth_voice_pkg::*;

    if (VOICES != NUM_VOICES) begin : g_bad_voices
        $error("voice_allocator: VOICES must be 8");
    end

    alloc_state_e                          state_q, state_d;
    logic [VOICE_IDX_W-1:0]                idx_q, idx_d;
    logic [VOICE_IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [SCAN_CNT_W-1:0]                 cnt_q, cnt_d;
    logic                                  ev_on_q, ev_on_d;
    logic [NOTE_W-1:0]                     ev_note_q, ev_note_d;
    logic [NUM_VOICES-1:0]                 gate_q, gate_d;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]     note_q, note_d;
    logic                                  voice_wr_q, voice_wr_d;
    logic [VOICE_IDX_W-1:0]                voice_sel_q, voice_sel_d;
    logic [NOTE_W-1:0]                     voice_note_q, voice_note_d;
    logic                                  voice_steal_q, voice_steal_d;
    logic                                  ev_drop_q, ev_drop_d;
    logic                                  hit_s;

    // A note-on wants a silent voice; a note-off wants a sounding voice holding the same note
    assign hit_s = ev_on_q ? ~gate_q[idx_q]
                           : (gate_q[idx_q] && (note_q[idx_q] == ev_note_q));

    // Next-state logic: scan/assign/release sequencing with panic overriding everything
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        gate_d        = gate_q;
        note_d        = note_q;
        voice_wr_d    = 1'b0;
        voice_sel_d   = voice_sel_q;
        voice_note_d  = voice_note_q;
        voice_steal_d = 1'b0;
        ev_drop_d     = 1'b0;
        if (panic) begin
            state_d = IDLE;
            gate_d  = {NUM_VOICES{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_valid) begin
                        ev_on_d   = ev_on;
                        ev_note_d = ev_note;
                        idx_d     = ev_on ? rr_ptr_q : 3'd0;
                        cnt_d     = 4'd0;
                        state_d   = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    if (hit_s) begin
                        state_d      = ev_on_q ? ASSIGN : RELEASE;
                        voice_wr_d   = 1'b1;
                        voice_sel_d  = idx_q;
                        voice_note_d = ev_on_q ? ev_note_q : note_q[idx_q];
                    end else if (cnt_q == 4'd7) begin
                        state_d = DONE;
                        if (ev_on_q) begin
`ifdef VOICE_STEAL_EN
                            state_d       = ASSIGN;
                            idx_d         = rr_ptr_q;
                            voice_wr_d    = 1'b1;
                            voice_sel_d   = rr_ptr_q;
                            voice_note_d  = ev_note_q;
                            voice_steal_d = 1'b1;
`else
                            ev_drop_d = 1'b1;
`endif
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ASSIGN: begin
                    gate_d[idx_q] = 1'b1;
                    note_d[idx_q] = ev_note_q;
                    rr_ptr_d      = idx_q + 3'd1;
                    state_d       = IDLE;
                end
                RELEASE: begin
                    gate_d[idx_q] = 1'b0;
                    state_d       = IDLE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= 3'd0;
            rr_ptr_q      <= 3'd0;
            cnt_q         <= 4'd0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= {NOTE_W{1'b0}};
            gate_q        <= {NUM_VOICES{1'b0}};
            note_q        <= {(NUM_VOICES*NOTE_W){1'b0}};
            voice_wr_q    <= 1'b0;
            voice_sel_q   <= 3'd0;
            voice_note_q  <= {NOTE_W{1'b0}};
            voice_steal_q <= 1'b0;
            ev_drop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            gate_q        <= gate_d;
            note_q        <= note_d;
            voice_wr_q    <= voice_wr_d;
            voice_sel_q   <= voice_sel_d;
            voice_note_q  <= voice_note_d;
            voice_steal_q <= voice_steal_d;
            ev_drop_q     <= ev_drop_d;
        end
    end

    assign ev_ready    = (state_q == IDLE);
    assign voice_wr    = voice_wr_q;
    assign voice_sel   = voice_sel_q;
    assign voice_note  = voice_note_q;
    assign voice_gate  = gate_q;
    assign voice_steal = voice_steal_q;
    assign ev_drop     = ev_drop_q;

    DMux8Way u_dmux (
        .in_i  (voice_wr_q),
        .sel_i (voice_sel_q),
        .out_o (voice_wr_vec)
    );
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized traffic vs. an event-level model.
module tb_voice_allocator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_on = 1'b0;
    logic [6:0] ev_note = 7'd0;
    logic       panic = 1'b0;
    logic       voice_wr;
    logic [2:0] voice_sel;
    logic [6:0] voice_note;
    logic [7:0] voice_wr_vec;
    logic [7:0] voice_gate;
    logic       voice_steal;
    logic       ev_drop;

    int n_vec = 0;
    int n_err = 0;

    voice_allocator dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .panic(panic), .voice_wr(voice_wr), .voice_sel(voice_sel),
        .voice_note(voice_note), .voice_wr_vec(voice_wr_vec), .voice_gate(voice_gate),
        .voice_steal(voice_steal), .ev_drop(ev_drop)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- event-level reference model ----------------
    localparam int K_ASSIGN = 0, K_RELEASE = 1, K_NONE = 2, K_DROP = 3;
    logic [7:0] m_gate;
    logic [6:0] m_note [8];
    int         m_rr, m_sel, m_kind, m_t, m_lat;
    bit         m_busy, m_steal;
    logic [6:0] m_evnote;
    bit         exp_ready, exp_wr, exp_steal, exp_drop;
    logic [2:0] exp_sel;
    logic [6:0] exp_vnote;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gate = 8'h00; m_rr = 0; m_busy = 0; m_t = 0;
            for (int v = 0; v < 8; v++) m_note[v] = 7'd0;
            exp_ready = 1; exp_wr = 0; exp_sel = 3'd0; exp_vnote = 7'd0;
            exp_steal = 0; exp_drop = 0;
        end else begin
            exp_wr = 0; exp_steal = 0; exp_drop = 0;
            if (panic) begin
                m_gate = 8'h00;
                m_busy = 0;
            end else if (m_busy) begin
                m_t++;
                if (m_t == m_lat) begin
                    if (m_kind == K_ASSIGN) begin
                        exp_wr = 1; exp_sel = 3'(m_sel); exp_vnote = m_evnote; exp_steal = m_steal;
                    end else if (m_kind == K_RELEASE) begin
                        exp_wr = 1; exp_sel = 3'(m_sel); exp_vnote = m_note[m_sel];
                    end else if (m_kind == K_DROP) begin
                        exp_drop = 1;
                    end
                end else if (m_t == m_lat + 1) begin
                    if (m_kind == K_ASSIGN) begin
                        m_gate[m_sel] = 1'b1;
                        m_note[m_sel] = m_evnote;
                        m_rr = (m_sel + 1) % 8;
                    end else if (m_kind == K_RELEASE) begin
                        m_gate[m_sel] = 1'b0;
                    end
                    m_busy = 0;
                end
            end else if (ev_valid) begin
                bit found;
                found = 0; m_steal = 0; m_lat = 8; m_kind = K_NONE; m_evnote = ev_note;
                // the k-th voice examined (k from 0) yields its strobe k+1 edges after acceptance
                for (int k = 0; k < 8; k++) begin
                    int v;
                    v = ev_on ? (m_rr + k) % 8 : k;
                    if (!found && (ev_on ? !m_gate[v] : (m_gate[v] && m_note[v] == ev_note))) begin
                        found = 1; m_sel = v; m_lat = k + 1;
                        m_kind = ev_on ? K_ASSIGN : K_RELEASE;
                    end
                end
                if (!found && ev_on) begin
`ifdef VOICE_STEAL_EN
                    m_kind = K_ASSIGN; m_sel = m_rr; m_steal = 1;
`else
                    m_kind = K_DROP;
`endif
                end
                m_busy = 1; m_t = 0;
            end
            exp_ready = !m_busy;
        end
    end

    // Single compare process: every cycle outside reset, all outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("ev_ready", 32'(ev_ready), 32'(exp_ready));
            chk("voice_wr", 32'(voice_wr), 32'(exp_wr));
            chk("voice_sel", 32'(voice_sel), 32'(exp_sel));
            chk("voice_note", 32'(voice_note), 32'(exp_vnote));
            chk("voice_wr_vec", 32'(voice_wr_vec), exp_wr ? (32'd1 << exp_sel) : 32'd0);
            chk("voice_gate", 32'(voice_gate), 32'(m_gate));
            chk("voice_steal", 32'(voice_steal), 32'(exp_steal));
            chk("ev_drop", 32'(ev_drop), 32'(exp_drop));
        end
    end

    // ---------------- directed helpers ----------------
    int         r_lat, r_rdy;
    logic [2:0] r_sel;
    logic [6:0] r_note;
    bit         r_steal, r_drop;

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!ev_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ev_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input bit on, input logic [6:0] n);
        wait_ready();
        ev_valid = 1'b1; ev_on = on; ev_note = n;
        @(negedge clk);
        ev_valid = 1'b0;
        r_lat = -1; r_rdy = -1; r_steal = 0; r_drop = 0;
        for (int c = 1; c <= 14; c++) begin
            if (voice_wr && r_lat < 0) begin
                r_lat = c; r_sel = voice_sel; r_note = voice_note; r_steal = voice_steal;
            end
            if (ev_drop) r_drop = 1;
            if (ev_ready) begin
                r_rdy = c;
                break;
            end
            @(negedge clk);
        end
        if (r_rdy < 0) chk("event_timeout", 32'd0, 32'd1);
    endtask

    logic [6:0] pool [6];

    initial begin
        pool[0] = 7'd60; pool[1] = 7'd64; pool[2] = 7'd67;
        pool[3] = 7'd72; pool[4] = 7'd0;  pool[5] = 7'd127;
        #1;
        chk("rst_ready", 32'(ev_ready), 32'd1);
        chk("rst_gate", 32'(voice_gate), 32'd0);
        chk("rst_wr", 32'(voice_wr), 32'd0);
        chk("rst_sel", 32'(voice_sel), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: three note-ons fill voices 0..2 with latency 2
        send(1'b1, 7'd60); chk("t1_sel0", 32'(r_sel), 32'd0); chk("t1_note0", 32'(r_note), 32'd60); chk("t1_lat0", 32'(r_lat), 32'd2);
        send(1'b1, 7'd64); chk("t1_sel1", 32'(r_sel), 32'd1); chk("t1_note1", 32'(r_note), 32'd64); chk("t1_lat1", 32'(r_lat), 32'd2);
        send(1'b1, 7'd67); chk("t1_sel2", 32'(r_sel), 32'd2); chk("t1_note2", 32'(r_note), 32'd67); chk("t1_lat2", 32'(r_lat), 32'd2);
        chk("t1_rdy", 32'(r_rdy), 32'd3);
        chk("t1_gate", 32'(voice_gate), 32'h07);

        // 2: release voice 1, next note-on goes to rr_ptr=3
        send(1'b0, 7'd64); chk("t2_rel_sel", 32'(r_sel), 32'd1); chk("t2_rel_lat", 32'(r_lat), 32'd3);
        chk("t2_gate", 32'(voice_gate), 32'h05);
        send(1'b1, 7'd72); chk("t2_on_sel", 32'(r_sel), 32'd3);

        // 3: note-off without a match
        send(1'b0, 7'd50);
        chk("t3_no_wr", 32'(r_lat), 32'hFFFF_FFFF);
        chk("t3_rdy", 32'(r_rdy), 32'd10);
        chk("t3_gate", 32'(voice_gate), 32'h0D);

        // 4: fill all voices then overflow
        send(1'b1, 7'd81); chk("t4_s4", 32'(r_sel), 32'd4);
        send(1'b1, 7'd82); chk("t4_s5", 32'(r_sel), 32'd5);
        send(1'b1, 7'd83); chk("t4_s6", 32'(r_sel), 32'd6);
        send(1'b1, 7'd84); chk("t4_s7", 32'(r_sel), 32'd7);
        send(1'b1, 7'd85); chk("t4_s1", 32'(r_sel), 32'd1);
        chk("t4_full", 32'(voice_gate), 32'hFF);
        send(1'b1, 7'd80);
`ifdef VOICE_STEAL_EN
        chk("t4_steal_sel", 32'(r_sel), 32'd2);
        chk("t4_steal_flag", 32'(r_steal), 32'd1);
        chk("t4_steal_lat", 32'(r_lat), 32'd9);
`else
        chk("t4_drop", 32'(r_drop), 32'd1);
        chk("t4_drop_no_wr", 32'(r_lat), 32'hFFFF_FFFF);
        chk("t4_drop_rdy", 32'(r_rdy), 32'd10);
`endif
        chk("t4_gate", 32'(voice_gate), 32'hFF);

        // 5: panic during SCAN
        ev_valid = 1'b1; ev_on = 1'b0; ev_note = 7'd99;
        @(negedge clk); ev_valid = 1'b0;
        @(negedge clk); panic = 1'b1;
        @(negedge clk); panic = 1'b0;
        chk("t5_gate", 32'(voice_gate), 32'h00);
        chk("t5_ready", 32'(ev_ready), 32'd1);
        chk("t5_no_wr", 32'(voice_wr), 32'd0);

        // 6: async reset mid-SCAN
        send(1'b1, 7'd33);
        ev_valid = 1'b1; ev_on = 1'b0; ev_note = 7'd99;
        @(negedge clk); ev_valid = 1'b0;
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_ready", 32'(ev_ready), 32'd1);
        chk("t6_gate", 32'(voice_gate), 32'h00);
        chk("t6_wr", 32'(voice_wr), 32'd0);
        chk("t6_sel", 32'(voice_sel), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        send(1'b1, 7'd10); chk("t6_sel_after", 32'(r_sel), 32'd0); chk("t6_lat_after", 32'(r_lat), 32'd2);

        // Randomized traffic, including requests while busy and sporadic panic
        for (int i = 0; i < 2500; i++) begin
            ev_valid = ($urandom_range(0, 99) < 60);
            ev_on    = ($urandom_range(0, 99) < 60);
            ev_note  = pool[$urandom_range(0, 5)];
            panic    = ($urandom_range(0, 99) < 2);
            @(negedge clk);
        end
        ev_valid = 1'b0; panic = 1'b0;
        wait_ready();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
